alu_muldiv_ctrl: RTL and testbench

ALU_MULDIV_CTRL -- requirements
Module: alu_muldiv_ctrl

---
 rtl/alu_muldiv_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_muldiv_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_ctrl.sv
// ALU control decode plus an iterative multiply/divide unit that owns the HI/LO registers.
// Multiply is shift-add and divide is restoring; both run on magnitudes and apply the sign in FIX.
module alu_muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [4:0]       ALUConf,
  output logic             Sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] MdOut
);
  localparam int unsigned        CW     = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

  localparam logic [4:0] CONF_AND = 5'd0;
  localparam logic [4:0] CONF_OR  = 5'd1;
  localparam logic [4:0] CONF_ADD = 5'd2;
  localparam logic [4:0] CONF_SUB = 5'd3;
  localparam logic [4:0] CONF_SLT = 5'd4;
  localparam logic [4:0] CONF_NOR = 5'd5;
  localparam logic [4:0] CONF_XOR = 5'd6;
  localparam logic [4:0] CONF_SLL = 5'd7;
  localparam logic [4:0] CONF_SRX = 5'd8;
  localparam logic [4:0] CONF_LUI = 5'd9;

  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_MULU = 6'h19;
  localparam logic [5:0] F_DIV  = 6'h1a;
  localparam logic [5:0] F_DIVU = 6'h1b;
  localparam logic [5:0] F_SLT  = 6'h2a;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  mq_q, mq_d;
  logic [WIDTH-1:0]  ma_q, ma_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              div0_q, div0_d;
  logic              is_div_q, is_div_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              is_rtype, op_mul, op_div, op_signed, neg_a, neg_b;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [WIDTH:0]    mul_sum, div_shift;
  logic              div_ge;
  logic [WIDTH-1:0]  div_sub, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  assign is_rtype  = (ALUOp == 4'd2);
  assign op_mul    = (Funct == F_MULT) || (Funct == F_MULU);
  assign op_div    = (Funct == F_DIV)  || (Funct == F_DIVU);
  assign op_signed = (Funct == F_MULT) || (Funct == F_DIV);

  // ALU operation decode
  always_comb begin
    ALUConf = CONF_ADD;
    case (ALUOp)
      4'd1:       ALUConf = CONF_SUB;
      4'd4:       ALUConf = CONF_AND;
      4'd5, 4'd6: ALUConf = CONF_SLT;
      4'd7:       ALUConf = CONF_OR;
      4'd8:       ALUConf = CONF_LUI;
      4'd2: begin
        case (Funct)
          6'h22, 6'h23: ALUConf = CONF_SUB;
          6'h24:        ALUConf = CONF_AND;
          6'h25:        ALUConf = CONF_OR;
          6'h26:        ALUConf = CONF_XOR;
          6'h27:        ALUConf = CONF_NOR;
          6'h00:        ALUConf = CONF_SLL;
          6'h02, 6'h03: ALUConf = CONF_SRX;
          6'h2a, 6'h2b: ALUConf = CONF_SLT;
          default:      ALUConf = CONF_ADD;
        endcase
      end
      default:    ALUConf = CONF_ADD;
    endcase
  end

  assign Sign = (is_rtype && (Funct == F_SRA || Funct == F_SLT ||
                              Funct == F_MULT || Funct == F_DIV)) || (ALUOp == 4'd5);

  assign neg_a = op_signed & A[WIDTH-1];
  assign neg_b = op_signed & B[WIDTH-1];
  assign a_mag = neg_a ? (~A + ONE_W) : A;
  assign b_mag = neg_b ? (~B + ONE_W) : B;

  // One shift-add step and one restoring-divide step per cycle
  assign mul_sum   = {1'b0, acc_q} + {1'b0, (mq_q[0] ? ma_q : '0)};
  assign div_shift = {acc_q, mq_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, ma_q});
  assign div_sub   = WIDTH'(div_shift - {1'b0, ma_q});

  assign prod_fix = (neg_a_q ^ neg_b_q) ? (~{acc_q, mq_q} + ONE_2W) : {acc_q, mq_q};
  assign quo_fix  = (neg_a_q ^ neg_b_q) ? (~mq_q + ONE_W) : mq_q;
  assign rem_fix  = neg_a_q ? (~acc_q + ONE_W) : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    ma_d     = ma_q;
    a_d      = a_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    div0_d   = div0_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && is_rtype && (op_mul || op_div)) begin
          state_d  = op_div ? S_DIV : S_MUL;
          cnt_d    = CW'(WIDTH);
          busy_d   = 1'b1;
          a_d      = A;
          neg_a_d  = neg_a;
          neg_b_d  = neg_b;
          div0_d   = (B == '0);
          is_div_d = op_div;
          acc_d    = '0;
          mq_d     = op_div ? a_mag : b_mag;
          ma_d     = op_div ? b_mag : a_mag;
        end else if (start && is_rtype && Funct == F_MTHI) begin
          hi_d = A;
        end else if (start && is_rtype && Funct == F_MTLO) begin
          lo_d = A;
        end
      end
      S_MUL: begin
        acc_d = mul_sum[WIDTH:1];
        mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (div0_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      ma_q     <= '0;
      a_q      <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      ma_q     <= ma_d;
      a_q      <= a_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      div0_q   <= div0_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign MdOut = (Funct == F_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Bench for alu_muldiv_ctrl: 64-bit arithmetic reference model with a per-cycle compare, plus literal pins.
module tb_alu_muldiv_ctrl;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   ALUOp = '0;
  logic [5:0]   Funct = '0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [4:0]   ALUConf;
  logic         Sign, busy, done;
  logic [W-1:0] MdOut;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  alu_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .Funct(Funct), .start(start),
    .A(A), .B(B), .ALUConf(ALUConf), .Sign(Sign), .busy(busy), .done(done), .MdOut(MdOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] exp_conf(input logic [3:0] op, input logic [5:0] f);
    logic [4:0] c;
    c = 5'd2;
    if (op == 4'd1) c = 5'd3;
    else if (op == 4'd4) c = 5'd0;
    else if (op == 4'd5 || op == 4'd6) c = 5'd4;
    else if (op == 4'd7) c = 5'd1;
    else if (op == 4'd8) c = 5'd9;
    else if (op == 4'd2) begin
      if (f inside {6'h22, 6'h23}) c = 5'd3;
      else if (f == 6'h24) c = 5'd0;
      else if (f == 6'h25) c = 5'd1;
      else if (f == 6'h26) c = 5'd6;
      else if (f == 6'h27) c = 5'd5;
      else if (f == 6'h00) c = 5'd7;
      else if (f inside {6'h02, 6'h03}) c = 5'd8;
      else if (f inside {6'h2a, 6'h2b}) c = 5'd4;
    end
    return c;
  endfunction

  function automatic logic exp_sign(input logic [3:0] op, input logic [5:0] f);
    return (op == 4'd5) || (op == 4'd2 && (f inside {6'h03, 6'h2a, 6'h18, 6'h1a}));
  endfunction

  // HI/LO result of a mul/div computed with wide native arithmetic
  task automatic mdres(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    hi = '0;
    lo = '0;
    if (f == 6'h18) begin
      p = sa * sb; hi = p[63:32]; lo = p[31:0];
    end else if (f == 6'h19) begin
      up = ua * ub; hi = up[63:32]; lo = up[31:0];
    end else if (b == 32'd0) begin
      hi = a; lo = '1;
    end else if (f == 6'h1a) begin
      p = sa / sb; lo = p[31:0];
      p = sa % sb; hi = p[31:0];
    end else begin
      lo = a / b; hi = a % b;
    end
  endtask

  int           m_cnt = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end else if (start && ALUOp == 4'd2) begin
        if (Funct inside {6'h18, 6'h19, 6'h1a, 6'h1b}) begin
          mdres(Funct, A, B, p_hi, p_lo);
          m_cnt = W + 1;
        end else if (Funct == 6'h11) m_hi = A;
        else if (Funct == 6'h13) m_lo = A;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_cnt > 0));
      chk("done", 64'(done), 64'(m_done));
      chk("mdout", 64'(MdOut), 64'((Funct == 6'h10) ? m_hi : m_lo));
      chk("aluconf", 64'(ALUConf), 64'(exp_conf(ALUOp, Funct)));
      chk("sign", 64'(Sign), 64'(exp_sign(ALUOp, Funct)));
    end
  end

  task automatic drive(input logic [3:0] op, input logic [5:0] f, input logic st,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk); #1;
    ALUOp = op; Funct = f; start = st; A = a; B = b;
  endtask

  task automatic read_hilo(input string nm, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    ALUOp = 4'd2; start = 1'b0;
    Funct = 6'h10; #1;
    chk({nm, "_hi"}, 64'(MdOut), 64'(ehi));
    Funct = 6'h12; #1;
    chk({nm, "_lo"}, 64'(MdOut), 64'(elo));
  endtask

  task automatic run_md(input string nm, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int nb;
    bit seen;
    nb = 0;
    seen = 1'b0;
    drive(4'd2, f, 1'b1, a, b);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin seen = 1'b1; break; end
      #1;
      start = 1'b0; A = $urandom; B = $urandom;
    end
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
    chk({nm, "_busy_len"}, 64'(nb), 64'(W + 1));
    read_hilo(nm, ehi, elo);
  endtask

  task automatic abort_case(input bit do_reset);
    bit seen;
    seen = 1'b0;
    drive(4'd2, 6'h19, 1'b1, 32'h0001_0000, 32'h0003_0000);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk); #1;
      start = (c == 10);
      Funct = (c == 10) ? 6'h1b : 6'h00;
      A = (c == 10) ? 32'd100 : $urandom;
      B = 32'd7;
      if (do_reset && c == 20) begin
        reset = 1'b0; #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        read_hilo("abort", 32'h0, 32'h0);
        Funct = 6'h00;
      end
      if (do_reset && c == 21) reset = 1'b1;
    end
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk(do_reset ? "abort_no_done" : "noabort_done", 64'(seen), do_reset ? 64'd0 : 64'd1);
    if (!do_reset) read_hilo("noabort", 32'h3, 32'h0);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    read_hilo("rst", 32'h0, 32'h0);
    chk_en = 1'b1;
    @(negedge clk); #1 reset = 1'b1;

    run_md("mult_m1x2", 6'h18, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md("divu_100_7", 6'h1b, 32'd100, 32'd7, 32'd2, 32'd14);
    run_md("div_m7_2", 6'h1a, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div_5_0", 6'h1a, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_md("div_min_m1", 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_md("multu_big", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

    drive(4'd2, 6'h11, 1'b1, 32'h1234, 32'h0);
    drive(4'd2, 6'h10, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("mthi_mdout", 64'(MdOut), 64'h1234);
    chk("mthi_busy", 64'(busy), 64'd0);

    for (int op = 0; op < 16; op++)
      for (int f = 0; f < 64; f++)
        drive(4'(op), 6'(f), 1'b0, $urandom, $urandom);
    drive(4'd2, 6'h27, 1'b0, 0, 0); #1;
    chk("conf_nor", 64'(ALUConf), 64'd5);
    Funct = 6'h03; #1;
    chk("conf_sra", 64'(ALUConf), 64'd8);
    chk("sign_sra", 64'(Sign), 64'd1);
    ALUOp = 4'd8; #1;
    chk("conf_lui", 64'(ALUConf), 64'd9);
    ALUOp = 4'd6; #1;
    chk("conf_sltiu", 64'(ALUConf), 64'd4);
    chk("sign_sltiu", 64'(Sign), 64'd0);

    abort_case(1'b1);
    abort_case(1'b0);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk); #1;
      ALUOp = ($urandom_range(0, 9) < 7) ? 4'd2 : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: Funct = 6'h18;
        1: Funct = 6'h19;
        2: Funct = 6'h1a;
        3: Funct = 6'h1b;
        4: Funct = 6'h11;
        5: Funct = 6'h13;
        6: Funct = 6'h10;
        default: Funct = 6'($urandom_range(0, 63));
      endcase
      start = ($urandom_range(0, 3) == 0);
      A = rand_operand();
      B = rand_operand();
      reset = ($urandom_range(0, 599) != 0);
    end
    drive(4'd0, 6'h00, 1'b0, 0, 0);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
